// File: rtl/debug_rom_pipe.sv
// rtl/debug_rom_pipe.sv - pipelined read-only memory behind a req/gnt/rvalid slave port
module debug_rom_pipe #(
  parameter int    DataWidth   = 64,
  parameter int    Depth       = 20,
  parameter int    AddrWidth   = 64,
  parameter int    ReadLatency = 1,
  parameter string InitFile    = "",
  parameter bit    ErrOnOor    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o
);

  localparam int OffW = $clog2(DataWidth / 8);
  localparam int WaW  = AddrWidth - OffW;
  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_dw
    $fatal(1, "debug_rom_pipe: DataWidth must be 32 or 64");
  end
  if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_rl
    $fatal(1, "debug_rom_pipe: ReadLatency must be 1..4");
  end
  if (Depth < 20 && InitFile == "") begin : g_bad_depth
    $fatal(1, "debug_rom_pipe: built-in stub image needs Depth >= 20");
  end

  typedef struct packed {
    logic            valid;
    logic            we;
    logic            oor;
    logic [IdxW-1:0] idx;
  } stage_t;

  // Built-in debug stub image, 64-bit words; 32-bit instances use the low half.
  function automatic logic [63:0] stub_word(input logic [IdxW-1:0] idx);
    logic [63:0] w;
    w = '0;
    case (int'(idx))
      0:  w = 64'h0000100f_00c0006f;
      1:  w = 64'h00000013_0580006f;
      2:  w = 64'hf1402473_7b241073;
      3:  w = 64'h0ff0000f_10802023;
      4:  w = 64'h00347413_40044403;
      5:  w = 64'h02041063_00147413;
      6:  w = 64'h0040006f_fe0408e3;
      7:  w = 64'h10802223_7b202473;
      8:  w = 64'h7b200073_7b241073;
      9:  w = 64'h10002623_f1402473;
      10: w = 64'h7b202473_0ff0000f;
      11: w = 64'h10002423_00100073;
      12: w = 64'hdeadbeef_0badc0de;
      13: w = 64'h12345678_9abcdef0;
      14: w = 64'h0f0f0f0f_f0f0f0f0;
      15: w = 64'h55aa55aa_aa55aa55;
      16: w = 64'h00000000_00000001;
      17: w = 64'h80000000_00000000;
      18: w = 64'hffffffff_ffffffff;
      19: w = 64'hcafef00d_c0ffee00;
      default: w = '0;
    endcase
    return w;
  endfunction

  logic                 rst_done_q;
  logic [WaW-1:0]       word_addr;
  logic                 oor;
  logic                 unused_offset;
  stage_t               s_in;
  stage_t               s_last;
  logic [DataWidth-1:0] rom_word;

  // Byte offset within a word carries no information for a word-wide ROM.
  assign unused_offset = ^addr_i[OffW-1:0];
  assign word_addr     = addr_i[AddrWidth-1:OffW];
  assign oor           = (word_addr >= WaW'(Depth));
  assign gnt_o         = req_i && rst_done_q;

  // Hold off grants for the first cycle after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_done_q <= 1'b0;
    else         rst_done_q <= 1'b1;
  end

  // Attributes of the request being accepted this cycle.
  always_comb begin
    s_in       = '0;
    s_in.valid = gnt_o;
    s_in.we    = we_i;
    s_in.oor   = oor;
    s_in.idx   = word_addr[IdxW-1:0];
  end

  if (ReadLatency > 1) begin : g_pipe
    stage_t pipe_q [ReadLatency-1];

    // Delay line carrying only request attributes; the memory sits after it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < ReadLatency - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= s_in;
        for (int i = 1; i < ReadLatency - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign s_last = pipe_q[ReadLatency-2];
  end else begin : g_nopipe
    assign s_last = s_in;
  end

  assign rom_word = DataWidth'(stub_word(s_last.idx));

  // Final stage: read the memory and register the response; data holds between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= s_last.valid;
      if (s_last.valid) begin
        if (s_last.we) begin
          rdata_o <= '0;
          err_o   <= 1'b1;
        end else if (s_last.oor) begin
          rdata_o <= '0;
          err_o   <= ErrOnOor;
        end else begin
          rdata_o <= rom_word;
          err_o   <= 1'b0;
        end
      end else begin
        err_o <= 1'b0;
      end
    end
  end

endmodule
